// File: rtl/risc5_div_fpu.sv
// RISC5 coprocessor: 32-bit integer divider, FP add/sub/FLT/FLOOR, FP divider.
// Latency 33 / 2 / 25 cycles; stall holds the CPU until every active unit is done.
module risc5_div_fpu (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_run,
  input  logic        div_sgn,
  input  logic        fad_run,
  input  logic        fad_u,
  input  logic        fad_v,
  input  logic        fdv_run,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        stall,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic [31:0] fsum,
  output logic [31:0] fquot
);

  localparam logic [5:0] DIV_N = 6'd33;
  localparam logic [1:0] FAD_N = 2'd2;
  localparam logic [4:0] FDV_N = 5'd25;

  logic [5:0] div_cnt;
  logic [1:0] fad_cnt;
  logic [4:0] fdv_cnt;

  assign stall = !rst && ((div_run && div_cnt != DIV_N) ||
                          (fad_run && fad_cnt != FAD_N) ||
                          (fdv_run && fdv_cnt != FDV_N));

  // integer divider
  logic [31:0] div_r, div_q, x_mag, d_rin, d_qin, d_rn, d_qn, quot_n, rem_n;
  logic [32:0] d_diff;
  logic        div_neg;

  always_comb begin
    div_neg = div_sgn & x[31];
    x_mag   = div_neg ? -x : x;
    d_rin   = (div_cnt == 6'd0) ? 32'd0 : div_r;
    d_qin   = (div_cnt == 6'd0) ? x_mag : div_q;
    d_diff  = {d_rin, d_qin[31]} - {1'b0, y};
    if (d_diff[32]) begin
      d_rn = {d_rin[30:0], d_qin[31]};
      d_qn = {d_qin[30:0], 1'b0};
    end else begin
      d_rn = d_diff[31:0];
      d_qn = {d_qin[30:0], 1'b1};
    end
    quot_n = div_q;
    rem_n  = div_r;
    // floored signed result: nonzero remainder rounds the quotient down
    if (div_neg) begin
      if (div_r != 32'd0) begin
        quot_n = ~div_q;
        rem_n  = y - div_r;
      end else begin
        quot_n = -div_q;
        rem_n  = 32'd0;
      end
    end
  end

  // floating-point divider
  logic [25:0] fdv_r, v_rin, v_rn, v_my;
  logic [23:0] fdv_q;
  logic [24:0] q25;
  logic [9:0]  ve;
  logic [31:0] fquot_n;
  logic        v_bit, v_sgn;

  always_comb begin
    v_my  = {2'b00, 1'b1, y[22:0]};
    v_rin = (fdv_cnt == 5'd0) ? {2'b00, 1'b1, x[22:0]} : fdv_r;
    v_bit = (v_rin >= v_my);
    v_rn  = (v_bit ? v_rin - v_my : v_rin) << 1;
    q25   = {fdv_q, v_bit};
    v_sgn = x[31] ^ y[31];
    ve    = {2'b00, x[30:23]} - {2'b00, y[30:23]} + 10'd127 - {9'd0, ~q25[24]};
    if (x[30:23] == 8'd0)
      fquot_n = 32'd0;
    else if (y[30:23] == 8'd0 || (!ve[9] && ve >= 10'd255))
      fquot_n = {v_sgn, 8'hFF, 23'd0};
    else if (ve[9] || ve == 10'd0)
      fquot_n = 32'd0;
    else
      fquot_n = {v_sgn, ve[7:0], q25[24] ? q25[23:1] : q25[22:0]};
  end

  // floating-point adder, FLT and FLOOR
  logic        fa_swap, nsign;
  logic [31:0] fa_big, fa_sml, x_abs, nw, nn, nres, f_ip, flr, fsum_n;
  logic [7:0]  fa_d, fe;
  logic [26:0] fa_mb, fa_ms, fa_al;
  logic [27:0] fa_s;
  logic [9:0]  nbase, ne;
  logic [4:0]  np;
  logic [23:0] nm;
  logic [54:0] fw;

  always_comb begin
    fa_swap = y[30:0] > x[30:0];
    fa_big  = fa_swap ? y : x;
    fa_sml  = fa_swap ? x : y;
    fa_d    = fa_big[30:23] - fa_sml[30:23];
    fa_mb   = {1'b1, fa_big[22:0], 3'b000};
    fa_ms   = {1'b1, fa_sml[22:0], 3'b000};
    if (fa_d >= 8'd27)
      fa_al = 27'd1;
    else
      fa_al = (fa_ms >> fa_d) | {26'd0, |(fa_ms & ~({27{1'b1}} << fa_d))};
    if (fa_big[31] == fa_sml[31])
      fa_s = {1'b0, fa_mb} + {1'b0, fa_al};
    else
      fa_s = {1'b0, fa_mb} - {1'b0, fa_al};

    // FLT shares the normalise/round path; weight of nw[30] is 2^(nbase-127)
    x_abs = x[31] ? -x : x;
    if (fad_u) begin
      nw    = x_abs;
      nbase = 10'd157;
      nsign = x[31];
    end else begin
      nw    = {fa_s, 4'd0};
      nbase = {2'b00, fa_big[30:23]};
      nsign = fa_big[31];
    end
    np = 5'd0;
    for (int i = 0; i < 32; i++)
      if (nw[i]) np = i[4:0];
    nn = nw << (5'd31 - np);
    nm = {1'b0, nn[30:8]} + {23'd0, nn[7]};
    ne = nbase + {5'd0, np} - 10'd30 + {9'd0, nm[23]};
    if (!nn[31] || ne[9] || ne == 10'd0)
      nres = 32'd0;
    else if (ne >= 10'd255)
      nres = {nsign, 8'hFF, 23'd0};
    else
      nres = {nsign, ne[7:0], nm[22:0]};

    fe   = x[30:23];
    fw   = {31'd0, 1'b1, x[22:0]} << (fe - 8'd127);
    f_ip = fw[54:23];
    if (fe == 8'd0)
      flr = 32'd0;
    else if (fe >= 8'd158)
      flr = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else if (fe < 8'd127)
      flr = x[31] ? 32'hFFFF_FFFF : 32'd0;
    else if (x[31])
      flr = -(f_ip + {31'd0, |fw[22:0]});
    else
      flr = f_ip;

    if (fad_u)                  fsum_n = nres;
    else if (fad_v)             fsum_n = flr;
    else if (x[30:23] == 8'd0)  fsum_n = y;
    else if (y[30:23] == 8'd0)  fsum_n = x;
    else                        fsum_n = nres;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      fad_cnt <= '0;
      fdv_cnt <= '0;
      div_r   <= '0;
      div_q   <= '0;
      fdv_r   <= '0;
      fdv_q   <= '0;
      quot    <= '0;
      rem     <= '0;
      fsum    <= '0;
      fquot   <= '0;
    end else begin
      div_cnt <= !div_run ? 6'd0 : (div_cnt == DIV_N) ? div_cnt : div_cnt + 6'd1;
      fad_cnt <= !fad_run ? 2'd0 : (fad_cnt == FAD_N) ? fad_cnt : fad_cnt + 2'd1;
      fdv_cnt <= !fdv_run ? 5'd0 : (fdv_cnt == FDV_N) ? fdv_cnt : fdv_cnt + 5'd1;
      if (div_run && div_cnt < 6'd32) begin
        div_r <= d_rn;
        div_q <= d_qn;
      end
      if (div_run && div_cnt == 6'd32) begin
        quot <= quot_n;
        rem  <= rem_n;
      end
      if (fad_run && fad_cnt == 2'd1)
        fsum <= fsum_n;
      if (fdv_run && fdv_cnt < 5'd24) begin
        fdv_r <= v_rn;
        fdv_q <= {fdv_q[22:0], v_bit};
      end
      if (fdv_run && fdv_cnt == 5'd24)
        fquot <= fquot_n;
    end
  end

endmodule

// File: tb/tb_risc5_div_fpu.sv
// Scoreboard bench for risc5_div_fpu: expected results queued at issue, checked when stall drops.
module tb_risc5_div_fpu;

  logic        clk = 1'b0;
  logic        rst, div_run, div_sgn, fad_run, fad_u, fad_v, fdv_run;
  logic [31:0] x, y;
  logic        stall;
  logic [31:0] quot, rem, fsum, fquot;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] q_quot[$], q_rem[$], q_fsum[$], q_fquot[$];
  logic [31:0] last_q, last_r;

  always #5 clk = ~clk;

  risc5_div_fpu dut (
    .clk(clk), .rst(rst), .div_run(div_run), .div_sgn(div_sgn),
    .fad_run(fad_run), .fad_u(fad_u), .fad_v(fad_v), .fdv_run(fdv_run),
    .x(x), .y(y), .stall(stall), .quot(quot), .rem(rem),
    .fsum(fsum), .fquot(fquot)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic div_model(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [31:0] q, output logic [31:0] r);
    logic [31:0] m;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s && a[31]) begin
      m = -a;
      if (m % b != 32'd0) begin
        q = -(m / b + 32'd1);
        r = b - m % b;
      end else begin
        q = -(m / b);
        r = 32'd0;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // cycles from run rising until stall falls, -1 if it never does
  task automatic wait_done(output int cyc);
    cyc = 0;
    #1;
    while (stall === 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (stall !== 1'b0) cyc = -1;
  endtask

  task automatic idle(input int n);
    div_run = 1'b0;
    fad_run = 1'b0;
    fdv_run = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic start_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] eq, er;
    div_model(a, b, s, eq, er);
    q_quot.push_back(eq);
    q_rem.push_back(er);
    x = a; y = b; div_sgn = s; div_run = 1'b1;
  endtask

  task automatic start_fad(input logic [31:0] a, input logic [31:0] b,
                           input logic u, input logic v, input logic [31:0] e);
    q_fsum.push_back(e);
    x = a; y = b; fad_u = u; fad_v = v; fad_run = 1'b1;
  endtask

  task automatic start_fdv(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    q_fquot.push_back(e);
    x = a; y = b; fdv_run = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset stall: got %b expected 0", stall); end
    n_checks++; if (quot !== 32'd0) begin n_fail++; $display("FAIL reset quot: got %h expected 0", quot); end
    n_checks++; if (rem !== 32'd0) begin n_fail++; $display("FAIL reset rem: got %h expected 0", rem); end
    n_checks++; if (fsum !== 32'd0) begin n_fail++; $display("FAIL reset fsum: got %h expected 0", fsum); end
    n_checks++; if (fquot !== 32'd0) begin n_fail++; $display("FAIL reset fquot: got %h expected 0", fquot); end
    div_run = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset run stall: got %b expected 0", stall); end
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset run stall2: got %b expected 0", stall); end
    div_run = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_div;
    logic [31:0] ta[5], ty[5], a, b, eq, er;
    logic ts[5];
    logic s;
    int cyc;
    ta = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF8, 32'h8000_0000, 32'h1234_5678};
    ty = '{32'd7, 32'd2, 32'd2, 32'd3, 32'd0};
    ts = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      if (i < 5) begin
        a = ta[i]; b = ty[i]; s = ts[i];
      end else begin
        a = $urandom;
        b = (i == 8) ? $urandom_range(32'hFFFF, 1) : $urandom_range(50, 1);
        s = i[0];
      end
      start_div(a, b, s);
      wait_done(cyc);
      eq = q_quot.pop_front();
      er = q_rem.pop_front();
      n_checks++; if (cyc != 33) begin n_fail++; $display("FAIL div[%0d] latency: got %0d expected 33", i, cyc); end
      n_checks++; if (quot !== eq) begin n_fail++; $display("FAIL div[%0d] quot: got %h expected %h", i, quot, eq); end
      n_checks++; if (rem !== er) begin n_fail++; $display("FAIL div[%0d] rem: got %h expected %h", i, rem, er); end
      idle(1);
    end
  endtask

  task automatic test_fadd;
    logic [31:0] ta[7], ty[7], te[7], e;
    int cyc;
    ta = '{32'h3FC0_0000, 32'h3F80_0000, 32'h4010_0000, 32'h3F80_0000,
           32'h7F00_0000, 32'h3F80_0000, 32'h0000_0000};
    ty = '{32'h4010_0000, 32'hBF80_0000, 32'hBFC0_0000, 32'h3380_0000,
           32'h7F00_0000, 32'h0000_0000, 32'hC040_0000};
    te = '{32'h4070_0000, 32'h0000_0000, 32'h3F40_0000, 32'h3F80_0001,
           32'h7F80_0000, 32'h3F80_0000, 32'hC040_0000};
    for (int i = 0; i < 7; i++) begin
      start_fad(ta[i], ty[i], 1'b0, 1'b0, te[i]);
      wait_done(cyc);
      e = q_fsum.pop_front();
      n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL fadd[%0d] latency: got %0d expected 2", i, cyc); end
      n_checks++; if (fsum !== e) begin n_fail++; $display("FAIL fadd[%0d] fsum: got %h expected %h", i, fsum, e); end
      idle(1);
    end
  endtask

  task automatic test_convert;
    logic [31:0] ta[11], te[11], e;
    logic tu[11], tv[11];
    int cyc;
    ta = '{32'hFFFF_FFFD, 32'h0000_0000, 32'h7FFF_FFFF, 32'h0100_0001,
           32'hBFC0_0000, 32'h4070_0000, 32'h4F00_0000, 32'hCF80_0000,
           32'h3F00_0000, 32'hBF00_0000, 32'hFFFF_FFFD};
    tu = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    te = '{32'hC040_0000, 32'h0000_0000, 32'h4F00_0000, 32'h4B80_0001,
           32'hFFFF_FFFE, 32'h0000_0003, 32'h7FFF_FFFF, 32'h8000_0000,
           32'h0000_0000, 32'hFFFF_FFFF, 32'hC040_0000};
    for (int i = 0; i < 11; i++) begin
      start_fad(ta[i], 32'h1234_5678, tu[i], tv[i], te[i]);
      wait_done(cyc);
      e = q_fsum.pop_front();
      n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL conv[%0d] latency: got %0d expected 2", i, cyc); end
      n_checks++; if (fsum !== e) begin n_fail++; $display("FAIL conv[%0d] fsum: got %h expected %h", i, fsum, e); end
      idle(1);
    end
    fad_u = 1'b0;
    fad_v = 1'b0;
  endtask

  task automatic test_fdiv;
    logic [31:0] ta[7], ty[7], te[7], e;
    int cyc;
    ta = '{32'h40E0_0000, 32'h40E0_0000, 32'h3F80_0000, 32'hC0E0_0000,
           32'h0000_0000, 32'h7F00_0000, 32'h0080_0000};
    ty = '{32'h4000_0000, 32'h0000_0000, 32'h4040_0000, 32'h4000_0000,
           32'h4000_0000, 32'h3F00_0000, 32'h7F00_0000};
    te = '{32'h4060_0000, 32'h7F80_0000, 32'h3EAA_AAAA, 32'hC060_0000,
           32'h0000_0000, 32'h7F80_0000, 32'h0000_0000};
    for (int i = 0; i < 7; i++) begin
      start_fdv(ta[i], ty[i], te[i]);
      wait_done(cyc);
      e = q_fquot.pop_front();
      n_checks++; if (cyc != 25) begin n_fail++; $display("FAIL fdiv[%0d] latency: got %0d expected 25", i, cyc); end
      n_checks++; if (fquot !== e) begin n_fail++; $display("FAIL fdiv[%0d] fquot: got %h expected %h", i, fquot, e); end
      idle(1);
    end
  endtask

  task automatic test_concurrent;
    logic [31:0] eq, er, ef;
    int cyc;
    start_div(32'h40E0_0000, 32'h4000_0000, 1'b0);
    start_fdv(32'h40E0_0000, 32'h4000_0000, 32'h4060_0000);
    wait_done(cyc);
    eq = q_quot.pop_front();
    er = q_rem.pop_front();
    ef = q_fquot.pop_front();
    n_checks++; if (cyc != 33) begin n_fail++; $display("FAIL concurrent latency: got %0d expected 33", cyc); end
    n_checks++; if (quot !== eq) begin n_fail++; $display("FAIL concurrent quot: got %h expected %h", quot, eq); end
    n_checks++; if (rem !== er) begin n_fail++; $display("FAIL concurrent rem: got %h expected %h", rem, er); end
    n_checks++; if (fquot !== ef) begin n_fail++; $display("FAIL concurrent fquot: got %h expected %h", fquot, ef); end
    last_q = eq;
    last_r = er;
    idle(1);
  endtask

  task automatic test_abort;
    logic [31:0] eq, er;
    int cyc;
    x = 32'd1000; y = 32'd3; div_sgn = 1'b0; div_run = 1'b1;
    repeat (10) @(negedge clk);
    div_run = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL abort stall: got %b expected 0", stall); end
    repeat (3) @(negedge clk);
    n_checks++; if (quot !== last_q) begin n_fail++; $display("FAIL abort quot held: got %h expected %h", quot, last_q); end
    n_checks++; if (rem !== last_r) begin n_fail++; $display("FAIL abort rem held: got %h expected %h", rem, last_r); end
    start_div(32'd1000, 32'd3, 1'b0);
    wait_done(cyc);
    eq = q_quot.pop_front();
    er = q_rem.pop_front();
    n_checks++; if (cyc != 33) begin n_fail++; $display("FAIL restart latency: got %0d expected 33", cyc); end
    n_checks++; if (quot !== eq) begin n_fail++; $display("FAIL restart quot: got %h expected %h", quot, eq); end
    n_checks++; if (rem !== er) begin n_fail++; $display("FAIL restart rem: got %h expected %h", rem, er); end
    idle(2);
  endtask

  initial begin
    rst = 1'b1;
    div_run = 1'b0; div_sgn = 1'b0;
    fad_run = 1'b0; fad_u = 1'b0; fad_v = 1'b0;
    fdv_run = 1'b0;
    x = 32'd0; y = 32'd0;
    last_q = 32'd0; last_r = 32'd0;
    test_reset();
    test_div();
    test_fadd();
    test_convert();
    test_fdiv();
    test_concurrent();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
